// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter: up/down, synchronous clear, Gray-coded parallel load, sticky wrap flags.
// Define GRAY_CNT_SAT_EN to build the saturating variant (count holds at the ends instead of wrapping).
module gray_counter_n #(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] INIT_BIN = '0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             En,
    input  logic             Dir,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Term
);

    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             term_q, term_d;
    logic [WIDTH-1:0] load_bin;
    logic             at_max;
    logic             at_min;

    always_comb begin
        load_bin = '0;
        load_bin[WIDTH-1] = LoadVal[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            load_bin[i] = load_bin[i+1] ^ LoadVal[i];
        end
    end

    assign at_max = (bin_q == {WIDTH{1'b1}});
    assign at_min = (bin_q == '0);

    always_comb begin
        bin_d  = bin_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        term_d = 1'b0;
        if (Clr) begin
            bin_d = INIT_BIN;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (Load) begin
            bin_d = load_bin;
        end else if (En) begin
            if (Dir) begin
                if (at_max) begin
                    ovf_d  = 1'b1;
                    term_d = 1'b1;
`ifdef GRAY_CNT_SAT_EN
                    bin_d  = bin_q;
`else
                    bin_d  = '0;
`endif
                end else begin
                    bin_d = bin_q + 1'b1;
                end
            end else begin
                if (at_min) begin
                    unf_d  = 1'b1;
                    term_d = 1'b1;
`ifdef GRAY_CNT_SAT_EN
                    bin_d  = bin_q;
`else
                    bin_d  = {WIDTH{1'b1}};
`endif
                end else begin
                    bin_d = bin_q - 1'b1;
                end
            end
        end
        // Gray is registered from the next binary value so Output never glitches.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            term_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            term_q <= term_d;
        end
    end

    assign Output    = gray_q;
    assign Binary    = bin_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Term      = term_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n (WIDTH=3, INIT_BIN=0): vector table, wrap/flag/reset
// sequences, then a random-direction walk checked against a reference model.
module tb_gray_counter_n;

    localparam int W = 3;

    logic         Clk;
    logic         Reset_n;
    logic         Clr;
    logic         Load;
    logic [W-1:0] LoadVal;
    logic         En;
    logic         Dir;
    logic [W-1:0] Output;
    logic [W-1:0] Binary;
    logic         Overflow;
    logic         Underflow;
    logic         Term;

    int n_checks;
    int n_fail;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         clr;
        logic         load;
        logic [W-1:0] lv;
        logic         en;
        logic         dir;
        logic [W-1:0] g;
        logic [W-1:0] b;
        logic         o;
        logic         u;
        logic         t;
    } vec_t;

    vec_t vecs[15];

    gray_counter_n #(.WIDTH(W), .INIT_BIN(3'd0)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Clr       (Clr),
        .Load      (Load),
        .LoadVal   (LoadVal),
        .En        (En),
        .Dir       (Dir),
        .Output    (Output),
        .Binary    (Binary),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Term      (Term)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [W-1:0] g, input logic [W-1:0] b,
                           input logic o, input logic u, input logic t);
        chk({name, ".gray"}, 32'(Output), 32'(g));
        chk({name, ".bin"},  32'(Binary), 32'(b));
        chk({name, ".ovf"},  32'(Overflow), 32'(o));
        chk({name, ".unf"},  32'(Underflow), 32'(u));
        chk({name, ".term"}, 32'(Term), 32'(t));
    endtask

    // driver: apply a command on the falling edge, sample 1 time unit after the rising edge
    task automatic drive(input logic clr, input logic load, input logic [W-1:0] lv,
                         input logic en, input logic dir);
        @(negedge Clk);
        Clr = clr; Load = load; LoadVal = lv; En = en; Dir = dir;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [W-1:0] mb;
        logic [W-1:0] prev_g;
        logic [W-1:0] eg;
        logic         d;
        n_checks = 0;
        n_fail   = 0;
        Reset_n = 1'b0;
        Clr = 0; Load = 0; LoadVal = '0; En = 0; Dir = 0;

        //                 clr load lv    en dir  gray   bin    o  u  t
        vecs[0]  = '{0, 0, 3'b000, 1, 1, 3'b001, 3'b001, 0, 0, 0};
        vecs[1]  = '{0, 0, 3'b000, 1, 1, 3'b011, 3'b010, 0, 0, 0};
        vecs[2]  = '{0, 0, 3'b000, 1, 1, 3'b010, 3'b011, 0, 0, 0};
        vecs[3]  = '{0, 0, 3'b000, 1, 1, 3'b110, 3'b100, 0, 0, 0};
        vecs[4]  = '{0, 0, 3'b000, 1, 1, 3'b111, 3'b101, 0, 0, 0};
        vecs[5]  = '{0, 0, 3'b000, 1, 1, 3'b101, 3'b110, 0, 0, 0};
        vecs[6]  = '{0, 0, 3'b000, 1, 1, 3'b100, 3'b111, 0, 0, 0};
        vecs[7]  = '{0, 1, 3'b010, 1, 1, 3'b010, 3'b011, 0, 0, 0};
        vecs[8]  = '{0, 0, 3'b000, 1, 0, 3'b011, 3'b010, 0, 0, 0};
        vecs[9]  = '{0, 0, 3'b000, 1, 1, 3'b010, 3'b011, 0, 0, 0};
        vecs[10] = '{0, 0, 3'b000, 0, 0, 3'b010, 3'b011, 0, 0, 0};
        vecs[11] = '{0, 1, 3'b111, 1, 1, 3'b111, 3'b101, 0, 0, 0};
        vecs[12] = '{0, 0, 3'b000, 1, 1, 3'b101, 3'b110, 0, 0, 0};
        vecs[13] = '{1, 1, 3'b111, 1, 1, 3'b000, 3'b000, 0, 0, 0};
        vecs[14] = '{0, 1, 3'b100, 0, 0, 3'b100, 3'b111, 0, 0, 0};

        #12;
        chk_all("reset", 3'b000, 3'b000, 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].dir);
            chk_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].b, vecs[i].o, vecs[i].u, vecs[i].t);
        end

        // counter is at binary 111: exercise the ends of the range
`ifdef GRAY_CNT_SAT_EN
        drive(0, 0, '0, 1, 1); chk_all("sat_up1", 3'b100, 3'b111, 1, 0, 1);
        drive(0, 0, '0, 1, 1); chk_all("sat_up2", 3'b100, 3'b111, 1, 0, 1);
        drive(0, 0, '0, 0, 1); chk_all("sat_hold", 3'b100, 3'b111, 1, 0, 0);
        drive(1, 0, '0, 0, 0); chk_all("sat_clr", 3'b000, 3'b000, 0, 0, 0);
        drive(0, 0, '0, 1, 0); chk_all("sat_dn", 3'b000, 3'b000, 0, 1, 1);
        drive(0, 0, '0, 0, 0); chk_all("sat_dn_hold", 3'b000, 3'b000, 0, 1, 0);
        drive(0, 0, '0, 1, 1); chk_all("sat_up_from0", 3'b001, 3'b001, 0, 1, 0);
`else
        drive(0, 0, '0, 1, 1); chk_all("wrap_up", 3'b000, 3'b000, 1, 0, 1);
        drive(0, 0, '0, 0, 1); chk_all("wrap_hold", 3'b000, 3'b000, 1, 0, 0);
        drive(0, 0, '0, 1, 0); chk_all("wrap_dn", 3'b100, 3'b111, 1, 1, 1);
        drive(0, 0, '0, 1, 1); chk_all("wrap_up2", 3'b000, 3'b000, 1, 1, 1);
        drive(0, 0, '0, 1, 1); chk_all("after_wrap", 3'b001, 3'b001, 1, 1, 0);
`endif
        drive(1, 1, 3'b101, 1, 1); chk_all("clr_prio", 3'b000, 3'b000, 0, 0, 0);

        // set Underflow, load Gray 110 (binary 100), then reset asynchronously mid-cycle
        drive(0, 0, '0, 1, 0);
        drive(0, 1, 3'b110, 0, 0); chk_all("pre_reset", 3'b110, 3'b100, 0, 1, 0);
        @(negedge Clk);
        Clr = 0; Load = 0; En = 1; Dir = 1;
        #2;
        Reset_n = 1'b0;
        #1;
        chk_all("async_reset", 3'b000, 3'b000, 0, 0, 0);
        @(posedge Clk);
        #1;
        chk_all("reset_held", 3'b000, 3'b000, 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        chk_all("first_edge", 3'b001, 3'b001, 0, 0, 0);

        // random-direction walk: model predicts the Gray value, each step must move at most one bit
        mb = 3'b001;
        prev_g = Output;
        for (int k = 0; k < 1000; k++) begin
            d = 1'($urandom_range(0, 1));
`ifdef GRAY_CNT_SAT_EN
            if (d && mb != 3'b111) mb = mb + 1'b1;
            else if (!d && mb != 3'b000) mb = mb - 1'b1;
`else
            mb = d ? mb + 1'b1 : mb - 1'b1;
`endif
            exp_q.push_back(to_gray(mb));
            drive(0, 0, '0, 1, d);
            eg = exp_q.pop_front();
            chk("walk.gray", 32'(Output), 32'(eg));
`ifdef GRAY_CNT_SAT_EN
            chk("walk.hamming_le1", 32'($countones(Output ^ prev_g) <= 1), 32'd1);
`else
            chk("walk.hamming", 32'($countones(Output ^ prev_g)), 32'd1);
`endif
            prev_g = Output;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
